// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter that lets NREQ requesters share one DEPTH x WIDTH bank of
// enabled D flip-flops through a req/gnt/ack handshake; the bank is exported in parallel.
module dff_bank_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*$clog2(DEPTH)-1:0] wr_addr,
    input  logic [NREQ*WIDTH-1:0]  wr_data,
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        ack,
    output logic [DEPTH*WIDTH-1:0] bank_q,
    output logic                   busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int IW = $clog2(NREQ);
    localparam int SW = IW + 1;

    typedef enum logic [0:0] {IDLE = 1'b0, XFER = 1'b1} state_t;

    state_t              state_reg, state_next;
    logic [IW-1:0]       rr_ptr_reg, rr_ptr_next;
    logic [IW-1:0]       win_reg, win_next;
    logic [NREQ-1:0]     gnt_reg, gnt_next;
    logic [NREQ-1:0]     ack_reg, ack_next;

    logic [AW-1:0]       addr_arr [NREQ];
    logic [WIDTH-1:0]    data_arr [NREQ];
    logic [WIDTH-1:0]    bank_reg [DEPTH];

    logic                found;
    logic [IW-1:0]       win_idx;
    logic [SW-1:0]       sum;
    logic [IW-1:0]       cand;

    logic                wr_en;
    logic [AW-1:0]       wr_sel_addr;
    logic [WIDTH-1:0]    wr_sel_data;

    // Unpack the per-requester slices so the winner can be selected by index.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign addr_arr[gi] = wr_addr[gi*AW +: AW];
            assign data_arr[gi] = wr_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // First set request at or after rr_ptr, wrapping at NREQ.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        sum     = '0;
        cand    = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, rr_ptr_reg} + SW'(k);
            if (sum >= SW'(NREQ)) begin
                sum = sum - SW'(NREQ);
            end
            cand = sum[IW-1:0];
            if (!found && req[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            rr_ptr_reg <= '0;
            win_reg    <= '0;
            gnt_reg    <= '0;
            ack_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            rr_ptr_reg <= rr_ptr_next;
            win_reg    <= win_next;
            gnt_reg    <= gnt_next;
            ack_reg    <= ack_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    state_next = found ? XFER : IDLE;
            XFER:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // An XFER always returns to IDLE; a dropped req turns it into a silent abort.
    always_comb begin
        gnt_next    = '0;
        ack_next    = '0;
        win_next    = win_reg;
        rr_ptr_next = rr_ptr_reg;
        wr_en       = 1'b0;
        wr_sel_addr = addr_arr[win_reg];
        wr_sel_data = data_arr[win_reg];
        case (state_reg)
            IDLE: begin
                if (found) begin
                    gnt_next[win_idx] = 1'b1;
                    win_next          = win_idx;
                end
            end
            XFER: begin
                rr_ptr_next = (win_reg == IW'(NREQ-1)) ? '0 : win_reg + 1'b1;
                if (req[win_reg]) begin
                    wr_en             = 1'b1;
                    ack_next[win_reg] = 1'b1;
                end
            end
            default: begin
                gnt_next = '0;
            end
        endcase
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_bank
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    bank_reg[gi] <= '0;
                end else if (wr_en && (wr_sel_addr == AW'(gi))) begin
                    bank_reg[gi] <= wr_sel_data;
                end
            end
            assign bank_q[gi*WIDTH +: WIDTH] = bank_reg[gi];
        end
    endgenerate

    assign gnt  = gnt_reg;
    assign ack  = ack_reg;
    assign busy = (state_reg == XFER);

    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_reg));
    a_ack_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(ack_reg));
    a_gnt_ack_excl: assert property (@(posedge clk) disable iff (!rst_n) (gnt_reg & ack_reg) == '0);

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed table-driven bench for dff_bank_arbiter (NREQ=4, WIDTH=8, DEPTH=4)
// plus a hand-written sequence for requests arriving during a transfer.
module tb_dff_bank_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic [31:0] bank_q;
    logic        busy;

    int checks;
    int failures;

    dff_bank_arbiter #(.NREQ(4), .WIDTH(8), .DEPTH(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .gnt     (gnt),
        .ack     (ack),
        .bank_q  (bank_q),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One row = inputs held across one rising edge + outputs expected after it.
    typedef struct {
        logic        rst_n;
        logic [3:0]  req;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  gnt;
        logic [3:0]  ack;
        logic        busy;
        logic [31:0] bank;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic [3:0] q, input logic [7:0] a,
                                input logic [31:0] d, input logic [3:0] g,
                                input logic [3:0] k, input logic b, input logic [31:0] bk);
        vec_t v;
        v.rst_n = r; v.req = q; v.addr = a; v.data = d;
        v.gnt = g; v.ack = k; v.busy = b; v.bank = bk;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        req      = 4'b0000;
        wr_addr  = 8'h00;
        wr_data  = 32'h0;

        // Reset with all requests asserted
        vecs.push_back(mk(1'b0, 4'b1111, 8'h00, 32'h0, 4'b0000, 4'b0000, 1'b0, 32'h0));
        vecs.push_back(mk(1'b0, 4'b1111, 8'h00, 32'h0, 4'b0000, 4'b0000, 1'b0, 32'h0));
        // Single write: requester 2 -> reg3 = A5
        vecs.push_back(mk(1'b1, 4'b0100, 8'h30, 32'h00A5_0000, 4'b0100, 4'b0000, 1'b1, 32'h0));
        vecs.push_back(mk(1'b1, 4'b0100, 8'h30, 32'h00A5_0000, 4'b0000, 4'b0100, 1'b0, 32'hA500_0000));
        vecs.push_back(mk(1'b1, 4'b0000, 8'h00, 32'h0, 4'b0000, 4'b0000, 1'b0, 32'hA500_0000));
        // Reset to bring rr_ptr back to 0
        vecs.push_back(mk(1'b0, 4'b0000, 8'h00, 32'h0, 4'b0000, 4'b0000, 1'b0, 32'h0));
        // Round robin, all requesting, requester i writes reg i
        vecs.push_back(mk(1'b1, 4'b1111, 8'hE4, 32'h4332_2110, 4'b0001, 4'b0000, 1'b1, 32'h0000_0000));
        vecs.push_back(mk(1'b1, 4'b1111, 8'hE4, 32'h4332_2110, 4'b0000, 4'b0001, 1'b0, 32'h0000_0010));
        vecs.push_back(mk(1'b1, 4'b1111, 8'hE4, 32'h4332_2110, 4'b0010, 4'b0000, 1'b1, 32'h0000_0010));
        vecs.push_back(mk(1'b1, 4'b1111, 8'hE4, 32'h4332_2110, 4'b0000, 4'b0010, 1'b0, 32'h0000_2110));
        vecs.push_back(mk(1'b1, 4'b1111, 8'hE4, 32'h4332_2110, 4'b0100, 4'b0000, 1'b1, 32'h0000_2110));
        vecs.push_back(mk(1'b1, 4'b1111, 8'hE4, 32'h4332_2110, 4'b0000, 4'b0100, 1'b0, 32'h0032_2110));
        vecs.push_back(mk(1'b1, 4'b1111, 8'hE4, 32'h4332_2110, 4'b1000, 4'b0000, 1'b1, 32'h0032_2110));
        vecs.push_back(mk(1'b1, 4'b1111, 8'hE4, 32'h4332_2110, 4'b0000, 4'b1000, 1'b0, 32'h4332_2110));
        vecs.push_back(mk(1'b1, 4'b1111, 8'hE4, 32'h4332_2110, 4'b0001, 4'b0000, 1'b1, 32'h4332_2110));
        vecs.push_back(mk(1'b1, 4'b1111, 8'hE4, 32'h4332_2155, 4'b0000, 4'b0001, 1'b0, 32'h4332_2155));
        vecs.push_back(mk(1'b1, 4'b0000, 8'h00, 32'h0, 4'b0000, 4'b0000, 1'b0, 32'h4332_2155));
        // Abort by requester 0, then requester 1 wins with req=0011
        vecs.push_back(mk(1'b1, 4'b0001, 8'h02, 32'h0000_0077, 4'b0001, 4'b0000, 1'b1, 32'h4332_2155));
        vecs.push_back(mk(1'b1, 4'b0000, 8'h02, 32'h0000_0077, 4'b0000, 4'b0000, 1'b0, 32'h4332_2155));
        vecs.push_back(mk(1'b1, 4'b0011, 8'h0A, 32'h0000_9977, 4'b0010, 4'b0000, 1'b1, 32'h4332_2155));
        vecs.push_back(mk(1'b1, 4'b0011, 8'h0A, 32'h0000_9977, 4'b0000, 4'b0010, 1'b0, 32'h4399_2155));
        vecs.push_back(mk(1'b1, 4'b0011, 8'h0A, 32'h0000_9977, 4'b0001, 4'b0000, 1'b1, 32'h4399_2155));
        vecs.push_back(mk(1'b1, 4'b0000, 8'h0A, 32'h0000_9977, 4'b0000, 4'b0000, 1'b0, 32'h4399_2155));
        vecs.push_back(mk(1'b1, 4'b0000, 8'h00, 32'h0, 4'b0000, 4'b0000, 1'b0, 32'h4399_2155));
        // Reset at the write edge drops the write and clears rr_ptr
        vecs.push_back(mk(1'b1, 4'b0001, 8'h01, 32'h0000_00EE, 4'b0001, 4'b0000, 1'b1, 32'h4399_2155));
        vecs.push_back(mk(1'b0, 4'b0001, 8'h01, 32'h0000_00EE, 4'b0000, 4'b0000, 1'b0, 32'h0));
        vecs.push_back(mk(1'b1, 4'b1111, 8'h00, 32'h0, 4'b0001, 4'b0000, 1'b1, 32'h0));
        vecs.push_back(mk(1'b1, 4'b0000, 8'h00, 32'h0, 4'b0000, 4'b0000, 1'b0, 32'h0));
        // Same address written twice; non-winner slices carry junk
        vecs.push_back(mk(1'b1, 4'b0001, 8'hF1, 32'hDEAD_BE11, 4'b0001, 4'b0000, 1'b1, 32'h0));
        vecs.push_back(mk(1'b1, 4'b0001, 8'hF1, 32'hDEAD_BE11, 4'b0000, 4'b0001, 1'b0, 32'h0000_1100));
        vecs.push_back(mk(1'b1, 4'b0010, 8'h07, 32'h0000_22FF, 4'b0010, 4'b0000, 1'b1, 32'h0000_1100));
        vecs.push_back(mk(1'b1, 4'b0010, 8'h07, 32'h0000_22FF, 4'b0000, 4'b0010, 1'b0, 32'h0000_2200));
        vecs.push_back(mk(1'b1, 4'b0000, 8'h00, 32'h0, 4'b0000, 4'b0000, 1'b0, 32'h0000_2200));

        for (int i = 0; i < vecs.size(); i++) begin
            rst_n   = vecs[i].rst_n;
            req     = vecs[i].req;
            wr_addr = vecs[i].addr;
            wr_data = vecs[i].data;
            step();
            $display("row %0d: rst_n=%b req=%b gnt=%b ack=%b busy=%b bank_q=%h",
                     i, rst_n, req, gnt, ack, busy, bank_q);
            check($sformatf("row%0d gnt", i), {28'h0, gnt}, {28'h0, vecs[i].gnt});
            check($sformatf("row%0d ack", i), {28'h0, ack}, {28'h0, vecs[i].ack});
            check($sformatf("row%0d busy", i), {31'h0, busy}, {31'h0, vecs[i].busy});
            check($sformatf("row%0d bank_q", i), bank_q, vecs[i].bank);
        end

        // Requester 2 arrives during requester 0's transfer and is served next.
        // rr_ptr is 2 here, bank holds reg1=22.
        req     = 4'b0001;
        wr_addr = 8'h00;
        wr_data = 32'h0000_005A;
        lat = 0;
        do begin
            step();
            lat++;
        end while (gnt !== 4'b0001 && lat < 8);
        $display("seq: grant to req0 after %0d cycle(s), gnt=%b", lat, gnt);
        check("seq grant latency", lat, 1);
        check("seq gnt0", {28'h0, gnt}, 32'h1);

        req     = 4'b0101;
        wr_addr = 8'h10;
        wr_data = 32'h0077_005A;
        step();
        $display("seq: write edge gnt=%b ack=%b bank_q=%h", gnt, ack, bank_q);
        check("seq ack0", {28'h0, ack}, 32'h1);
        check("seq gnt idle", {28'h0, gnt}, 32'h0);
        check("seq bank write", bank_q, 32'h0000_225A);

        step();
        $display("seq: next grant gnt=%b busy=%b", gnt, busy);
        check("seq gnt2 fair", {28'h0, gnt}, 32'h4);
        check("seq busy", {31'h0, busy}, 32'h1);

        req = 4'b0000;
        step();
        $display("seq: abort req2 gnt=%b ack=%b bank_q=%h", gnt, ack, bank_q);
        check("seq abort ack", {28'h0, ack}, 32'h0);
        check("seq abort bank", bank_q, 32'h0000_225A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
